// File: rtl/gray_bcd_stream_checker.sv
// ---------------------------------------------------------------------------
// gray_bcd_stream_checker
//
// Receive-side companion to the 3-bit BCD/Gray sequence generator. Every
// clock it samples the generator's counter bus and mode control, decodes
// Gray words to binary, locks onto the +1 (mod 8) stepping sequence, flags
// each illegal step seen while locked and keeps a saturating error count.
//
// Parameters
//   LOCK_COUNT  consecutive legal steps needed to declare lock (1..15)
//   MISS_LIMIT  consecutive illegal steps while locked that force
//               re-acquisition (1..15)
//   ERR_W       width of the error counter
//
// Ports
//   clk         sole clock, rising-edge active
//   reset       synchronous, active-high reset
//   control     sequence mode: 0 = plain binary count, 1 = Gray count
//   counter     3-bit code word from the generator
//   binary_out  registered binary decode of the last sampled code word
//   locked      high while the FSM is in LOCKED
//   err_flag    one-cycle pulse per illegal step detected while locked
//   wrap_flag   one-cycle pulse when a locked sequence steps 7 -> 0
//   err_count   saturating count of illegal steps since reset
// ---------------------------------------------------------------------------
module gray_bcd_stream_checker #(
    parameter int unsigned LOCK_COUNT = 3,
    parameter int unsigned MISS_LIMIT = 2,
    parameter int unsigned ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             control,
    input  logic [2:0]       counter,
    output logic [2:0]       binary_out,
    output logic             locked,
    output logic             err_flag,
    output logic             wrap_flag,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0]       LOCK_TARGET = 4'(LOCK_COUNT);
    localparam logic [3:0]       MISS_TARGET = 4'(MISS_LIMIT);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    state_t     state;
    state_t     state_next;
    logic [2:0] prev;
    logic       prev_mode;
    logic [3:0] good_cnt;
    logic [3:0] good_next;
    logic [3:0] miss_cnt;
    logic [3:0] miss_next;

    logic [2:0] decoded;
    logic [2:0] prev_inc;
    logic [3:0] good_inc;
    logic [3:0] miss_inc;
    logic       step_legal;
    logic       mode_change;
    logic       err_hit;
    logic       wrap_hit;

    // -----------------------------------------------------------------------
    // Decode and step classification
    // -----------------------------------------------------------------------
    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above
    // its position, which is exactly the reduction-XOR of the upper slice.
    always_comb begin
        if (control) begin
            decoded = {counter[2], ^counter[2:1], ^counter[2:0]};
        end else begin
            decoded = counter;
        end
    end

    // prev_inc is held in a 3-bit variable so 7 + 1 wraps to 0 and the
    // 7 -> 0 step compares as legal.
    assign prev_inc    = prev + 3'd1;
    assign good_inc    = good_cnt + 4'd1;
    assign miss_inc    = miss_cnt + 4'd1;
    assign step_legal  = (decoded == prev_inc);
    assign mode_change = (control != prev_mode);

    // -----------------------------------------------------------------------
    // Process 1: state and datapath registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            prev       <= '0;
            prev_mode  <= 1'b0;
            good_cnt   <= '0;
            miss_cnt   <= '0;
            binary_out <= '0;
            err_flag   <= 1'b0;
            wrap_flag  <= 1'b0;
            err_count  <= '0;
        end else begin
            state      <= state_next;
            good_cnt   <= good_next;
            miss_cnt   <= miss_next;
            // prev/prev_mode and binary_out follow the stream in every state,
            // so a mode change automatically re-seeds from the current sample.
            prev       <= decoded;
            prev_mode  <= control;
            binary_out <= decoded;
            err_flag   <= err_hit;
            wrap_flag  <= wrap_hit;
            if (err_hit && (err_count != ERR_MAX)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Process 2: next-state and counter update logic
    // -----------------------------------------------------------------------
    // NOTE: every variable driven here gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    always_comb begin
        state_next = state;
        good_next  = good_cnt;
        miss_next  = miss_cnt;
        err_hit    = 1'b0;
        wrap_hit   = 1'b0;

        case (state)
            ST_IDLE: begin
                // First sample after reset only seeds prev; no step to judge.
                state_next = ST_ACQUIRE;
                good_next  = '0;
            end

            ST_ACQUIRE: begin
                if (mode_change) begin
                    good_next = '0;
                end else if (step_legal) begin
                    good_next = good_inc;
                    if (good_inc == LOCK_TARGET) begin
                        state_next = ST_LOCKED;
                        miss_next  = '0;
                    end
                end else begin
                    // Mismatches while hunting for lock are not errors.
                    good_next = '0;
                end
            end

            ST_LOCKED: begin
                if (mode_change) begin
                    // A deliberate mode switch is re-acquired, never flagged.
                    state_next = ST_ACQUIRE;
                    good_next  = '0;
                end else if (step_legal) begin
                    miss_next = '0;
                    wrap_hit  = (prev == 3'd7);
                end else begin
                    err_hit   = 1'b1;
                    miss_next = miss_inc;
                    if (miss_inc == MISS_TARGET) begin
                        state_next = ST_ACQUIRE;
                        good_next  = '0;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
                good_next  = '0;
                miss_next  = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Process 3: state-decoded outputs
    // -----------------------------------------------------------------------
    always_comb begin
        locked = (state == ST_LOCKED);
    end

endmodule

// File: tb/tb_gray_bcd_stream_checker.sv
// ---------------------------------------------------------------------------
// tb_gray_bcd_stream_checker
//
// Drives two checkers from one stimulus stream: one with default parameters
// and one with ERR_W=2 to exercise err_count saturation. Expected outputs
// come from a behavioural model that decodes Gray words by table position
// and follows the lock/miss rules with plain integers.
// ---------------------------------------------------------------------------
module tb_gray_bcd_stream_checker;

    localparam int LOCK_COUNT = 3;
    localparam int MISS_LIMIT = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       control = 1'b0;
    logic [2:0] counter = 3'd0;

    logic [2:0] binary_out;
    logic       locked;
    logic       err_flag;
    logic       wrap_flag;
    logic [7:0] err_count;

    logic [2:0] sat_binary_out;
    logic       sat_locked;
    logic       sat_err_flag;
    logic       sat_wrap_flag;
    logic [1:0] sat_err_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gray_bcd_stream_checker u_dut (
        .clk        (clk),
        .reset      (reset),
        .control    (control),
        .counter    (counter),
        .binary_out (binary_out),
        .locked     (locked),
        .err_flag   (err_flag),
        .wrap_flag  (wrap_flag),
        .err_count  (err_count)
    );

    gray_bcd_stream_checker #(.ERR_W(2)) u_dut_sat (
        .clk        (clk),
        .reset      (reset),
        .control    (control),
        .counter    (counter),
        .binary_out (sat_binary_out),
        .locked     (sat_locked),
        .err_flag   (sat_err_flag),
        .wrap_flag  (sat_wrap_flag),
        .err_count  (sat_err_count)
    );

    // Gray sequence by position: gray_seq[n] is the code word for count n.
    logic [2:0] gray_seq [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

    // ---------------- reference model ----------------
    // phase: 0 = waiting for first sample, 1 = hunting, 2 = locked
    int m_phase, m_good, m_miss, m_prev, m_prev_mode, m_errs;
    int exp_bin, exp_err, exp_wrap;

    function automatic int decode(input logic c, input logic [2:0] w);
        if (!c) return int'(w);
        for (int i = 0; i < 8; i++) begin
            if (gray_seq[i] == w) return i;
        end
        return 0;
    endfunction

    function automatic logic [2:0] encode(input logic c, input int v);
        return c ? gray_seq[v % 8] : 3'(v % 8);
    endfunction

    task automatic model_edge(input logic r, input logic c, input logic [2:0] w);
        int v;
        exp_err  = 0;
        exp_wrap = 0;
        if (r) begin
            m_phase = 0; m_good = 0; m_miss = 0; m_prev = 0; m_prev_mode = 0;
            m_errs = 0; exp_bin = 0;
            return;
        end
        v = decode(c, w);
        if (m_phase == 0 || int'(c) != m_prev_mode) begin
            m_phase = 1;
            m_good  = 0;
        end else if (m_phase == 1) begin
            if (v == (m_prev + 1) % 8) begin
                m_good++;
                if (m_good == LOCK_COUNT) begin
                    m_phase = 2;
                    m_miss  = 0;
                end
            end else begin
                m_good = 0;
            end
        end else begin
            if (v == (m_prev + 1) % 8) begin
                m_miss   = 0;
                exp_wrap = (m_prev == 7) ? 1 : 0;
            end else begin
                exp_err = 1;
                m_errs++;
                m_miss++;
                if (m_miss == MISS_LIMIT) begin
                    m_phase = 1;
                    m_good  = 0;
                end
            end
        end
        m_prev      = v;
        m_prev_mode = int'(c);
        exp_bin     = v;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Applies one sample, lets the rising edge take it, then compares all
    // outputs at the following falling edge.
    task automatic step(input logic r, input logic c, input logic [2:0] w);
        reset   = r;
        control = c;
        counter = w;
        @(posedge clk);
        model_edge(r, c, w);
        @(negedge clk);
        check("binary_out", int'(binary_out), exp_bin);
        check("locked",     int'(locked),     (m_phase == 2) ? 1 : 0);
        check("err_flag",   int'(err_flag),   exp_err);
        check("wrap_flag",  int'(wrap_flag),  exp_wrap);
        check("err_count",  int'(err_count),  (m_errs > 255) ? 255 : m_errs);
        check("sat_err_count", int'(sat_err_count), (m_errs > 3) ? 3 : m_errs);
        check("sat_err_flag",  int'(sat_err_flag),  exp_err);
    endtask

    task automatic feed(input logic c, input int v);
        step(1'b0, c, encode(c, v));
    endtask

    initial begin
        int v;
        logic c;
        int r;

        // Reset state
        @(negedge clk);
        step(1'b1, 1'b0, 3'd0);
        step(1'b1, 1'b0, 3'd5);

        // Binary count through a wrap
        for (int i = 0; i < 10; i++) feed(1'b0, i);

        // Gray count through a wrap
        step(1'b1, 1'b1, 3'd0);
        for (int i = 0; i < 9; i++) feed(1'b1, i);

        // Locked binary stream, single skip 3 -> 5, then resume
        step(1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) feed(1'b0, i);
        feed(1'b0, 5); feed(1'b0, 6); feed(1'b0, 7);

        // Stall at 4, lose lock, relock
        step(1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 5; i++) feed(1'b0, i);
        feed(1'b0, 4); feed(1'b0, 4); feed(1'b0, 4);
        for (int i = 5; i < 10; i++) feed(1'b0, i);

        // Mode switch while locked, relock in Gray
        step(1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 6; i++) feed(1'b0, i);
        for (int i = 6; i < 11; i++) feed(1'b1, i);

        // Five isolated errors: saturates the ERR_W=2 counter
        step(1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) feed(1'b0, i);
        v = 3;
        for (int k = 0; k < 5; k++) begin
            v = v + 2; feed(1'b0, v);
            v = v + 1; feed(1'b0, v);
        end

        // Reset asserted on a cycle carrying a miss
        feed(1'b0, v + 3);
        step(1'b1, 1'b0, 3'(v + 6));
        step(1'b1, 1'b0, 3'd0);

        // Randomized stream: mostly legal steps with stalls, jumps,
        // mode switches and occasional resets
        c = 1'b0;
        v = 0;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 1) begin
                step(1'b1, c, 3'($urandom_range(0, 7)));
                continue;
            end else if (r < 5) begin
                c = ~c; v = v + 1;
            end else if (r < 12) begin
                v = v;
            end else if (r < 20) begin
                v = $urandom_range(0, 7);
            end else begin
                v = v + 1;
            end
            v = v % 8;
            feed(c, v);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gray_bcd_stream_checker.md
# gray_bcd_stream_checker

- Receive-side companion to the 3-bit BCD/Gray sequence generator.
- Samples the generator's counter bus and mode control every clock and decodes Gray values to binary.
- Locks onto the stepping sequence, flags every illegal step and counts errors.
- Sits downstream of the generator and feeds status LEDs and the lab verification harness.

## Interface
Parameters:
- LOCK_COUNT, 3: consecutive legal steps needed to declare lock (1–15).
- MISS_LIMIT, 2: consecutive illegal steps while locked that force re-acquisition (1–15).
- ERR_W, 8: width of the error counter.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- control  input  1  sequence mode: 0 = plain binary (BCD) count, 1 = Gray count.
- counter  input  3  code word from the generator.
- binary_out  output  3  registered binary decode of the last sampled code word.
- locked  output  1  high while in LOCKED state.
- err_flag  output  1  one-cycle pulse per illegal step detected while locked.
- wrap_flag  output  1  one-cycle pulse when a locked sequence steps decoded 7 -> 0.
- err_count  output  ERR_W  saturating count of illegal steps since reset.

## Operation
- Decode:
  - control=0: value is counter as-is.
  - control=1: b2=g2, b1=g2^g1, b0=b1^g0.
  - Gray order is 000,001,011,010,110,111,101,100.
- Legal step: decoded value == (previous decoded value + 1) mod 8. Arithmetic is 3-bit, so 7 -> 0 is legal.
- Illegal step: any other value, including a repeated (stalled) value.
- Internal state: prev (3 bits), prev_mode (1 bit), good_cnt (4 bits), miss_cnt (4 bits), FSM.
- FSM states:
  - IDLE: entered on reset. Next edge stores prev/prev_mode, clears good_cnt, and goes to ACQUIRE.
  - ACQUIRE:
    - Legal step: good_cnt+1. When good_cnt reaches LOCK_COUNT, go to LOCKED with miss_cnt=0.
    - Illegal step: good_cnt=0, stay in ACQUIRE. Errors are not counted and err_flag stays low.
  - LOCKED:
    - Legal step: miss_cnt=0. Pulse wrap_flag if prev==7.
    - Illegal step: pulse err_flag, increment err_count (saturating at 2^ERR_W-1), miss_cnt+1.
    - When miss_cnt reaches MISS_LIMIT, go to ACQUIRE with good_cnt=0.
- Mode change (control != prev_mode) in any state:
  - Never an error.
  - Go to ACQUIRE with good_cnt=0 and re-seed prev from the current sample.
  - Mode change takes priority over step evaluation in the same cycle.
- prev and prev_mode update on every non-reset edge.
- binary_out updates on every non-reset edge, in all states.

## Timing
- Reset values: binary_out=0, locked=0, err_flag=0, wrap_flag=0, err_count=0, FSM=IDLE, all internal counters 0.
- Reset mid-operation wins over every other event in that cycle, including a pending err_count increment.
- binary_out latency: 1 cycle (sample at edge N, visible after edge N).
- err_flag and wrap_flag are asserted for exactly the cycle after the edge that sampled the offending or wrapping value. They never stretch.
- Lock latency from reset with a clean stream:
  - 1 edge to leave IDLE, then LOCK_COUNT edges in ACQUIRE.
  - locked rises after edge 1+LOCK_COUNT (edge 4 at defaults).
- locked falls on the same edge that records the MISS_LIMIT-th consecutive miss. err_flag is also pulsed for that miss.
- err_count at saturation holds its value; err_flag still pulses.

## Test plan
- Reset, control=0, feed 0,1,2,…,7,0,1 one per cycle:
  - locked=1 after 4th edge, binary_out tracks the input 1 cycle late.
  - wrap_flag pulses once after the 7->0 sample.
  - err_count stays 0.
- control=1, feed Gray 000,001,011,010,110,111,101,100,000:
  - binary_out shows 0..7,0.
  - locked after 4th edge, one wrap_flag pulse, no err_flag.
- Locked binary stream, inject 3,5 then resume 6,7:
  - One err_flag pulse and err_count=1 after the 5; miss_cnt clears at the 6.
  - locked stays 1.
- Locked stream, then hold the value 4 for three cycles:
  - err_flag pulses twice.
  - locked drops after the 2nd miss; err_count=2.
  - Third 4 is an ACQUIRE mismatch: err_count unchanged.
  - Relock 3 legal steps later.
- Locked binary stream, switch control 0->1 mid-stream:
  - No err_flag, locked drops next edge.
  - Relocks after 3 legal Gray steps.
- ERR_W=2, force 5 isolated errors (each followed by a legal step):
  - err_count sticks at 3; err_flag pulses all 5 times.
- Assert reset during a miss cycle: all outputs return to 0 after that edge.
